// File: rtl/mul_iter_seq_if.sv
// Handshake bundle for the iterative multiplier: an operand channel (in_*),
// a result channel (out_*, c) and the busy status flag.
`timescale 1ns/1ps
interface mul_iter_seq_if #(
  parameter int WIDTH = 24
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               sgn;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] c;
  logic               busy;

  // The producer/consumer side that drives operands and accepts results.
  modport master (
    output in_valid, a, b, sgn, out_ready,
    input  in_ready, out_valid, c, busy
  );

  // The multiplier side.
  modport slave (
    input  in_valid, a, b, sgn, out_ready,
    output in_ready, out_valid, c, busy
  );
endinterface

// File: rtl/mul_iter_seq.sv
// Iterative WIDTH x WIDTH multiplier, unsigned or two's-complement.
// One DIGIT-bit row of the multiplier magnitude is folded into the
// accumulator per clock, so a product takes N = WIDTH/DIGIT RUN cycles.
// Signed operands are reduced to magnitudes up front and the sign is
// reapplied to the final 2*WIDTH-bit sum. WIDTH must be a multiple of DIGIT.
`timescale 1ns/1ps
module mul_iter_seq #(
  parameter int WIDTH = 24,
  parameter int DIGIT = 8
) (
  input logic          clk,
  input logic          rst,
  mul_iter_seq_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   ma_sh;     // |a|, pre-shifted to the weight of the current digit
  logic [WIDTH-1:0] mb_sh;    // |b|, current digit always in the low DIGIT bits
  logic            neg;
  logic [PW-1:0]   c_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   acc_next;
  logic            last;

  // Magnitudes: -2^(W-1) negates to itself, which read unsigned is 2^(W-1),
  // so a plain W-bit register holds every magnitude without overflow.
  assign a_mag = (bus.sgn && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
  assign b_mag = (bus.sgn && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

  // One partial-product row; ma_sh already carries the digit's weight.
  assign pp       = ma_sh * {{(PW-DIGIT){1'b0}}, mb_sh[DIGIT-1:0]};
  assign acc_next = acc + pp;
  assign last     = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: state elements take non-blocking assignments so every flop
      // samples the pre-edge values regardless of block ordering.
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: assigning the default first means every path writes state_d,
    // so no latch is inferred when a branch leaves it untouched.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one row per RUN cycle, result load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      ma_sh <= '0;
      mb_sh <= '0;
      neg   <= 1'b0;
      c_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            ma_sh <= {{WIDTH{1'b0}}, a_mag};
            mb_sh <= b_mag;
            neg   <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          cnt   <= cnt + CW'(1);
          ma_sh <= ma_sh << DIGIT;
          mb_sh <= mb_sh >> DIGIT;
          if (last) begin
            c_q <= neg ? (~acc_next + PW'(1)) : acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.c         = c_q;

endmodule

// File: tb/tb_mul_iter_seq.sv
// Bench for mul_iter_seq: default 24/8 instance for directed vectors,
// back-pressure, mid-run reset and streaming; 32/4 and 16/16 instances for
// the parameter sweep. Expected products come from plain 64-bit arithmetic.
`timescale 1ns/1ps
module tb_mul_iter_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_iter_seq_if #(.WIDTH(24)) b24 ();
  mul_iter_seq_if #(.WIDTH(32)) b32 ();
  mul_iter_seq_if #(.WIDTH(16)) b16 ();

  mul_iter_seq #(.WIDTH(24), .DIGIT(8))  dut24 (.clk(clk), .rst(rst), .bus(b24));
  mul_iter_seq #(.WIDTH(32), .DIGIT(4))  dut32 (.clk(clk), .rst(rst), .bus(b32));
  mul_iter_seq #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: sign- or zero-extend to 64 bits, multiply, keep 2w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input bit s);
    longint unsigned m, ae, be, pm;
    m  = (64'd1 << w) - 64'd1;
    ae = a & m;
    be = b & m;
    if (s && ae[w-1]) ae = ae | ~m;
    if (s && be[w-1]) be = be | ~m;
    pm = (w >= 32) ? '1 : ((64'd1 << (2*w)) - 64'd1);
    return (ae * be) & pm;
  endfunction

  function automatic int wid(input int sel);
    return (sel == 0) ? 24 : (sel == 1) ? 32 : 16;
  endfunction

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 3 : (sel == 1) ? 8 : 1;
  endfunction

  task automatic drive(input int sel, input bit v, input logic [63:0] a,
                       input logic [63:0] b, input bit s);
    case (sel)
      0: begin b24.in_valid = v; b24.a = a[23:0]; b24.b = b[23:0]; b24.sgn = s; end
      1: begin b32.in_valid = v; b32.a = a[31:0]; b32.b = b[31:0]; b32.sgn = s; end
      default: begin b16.in_valid = v; b16.a = a[15:0]; b16.b = b[15:0]; b16.sgn = s; end
    endcase
  endtask

  task automatic set_ordy(input int sel, input bit v);
    case (sel)
      0: b24.out_ready = v;
      1: b32.out_ready = v;
      default: b16.out_ready = v;
    endcase
  endtask

  function automatic bit ovld(input int sel);
    return (sel == 0) ? b24.out_valid : (sel == 1) ? b32.out_valid : b16.out_valid;
  endfunction

  function automatic bit irdy(input int sel);
    return (sel == 0) ? b24.in_ready : (sel == 1) ? b32.in_ready : b16.in_ready;
  endfunction

  function automatic logic [63:0] getc(input int sel);
    return (sel == 0) ? {16'h0, b24.c} : (sel == 1) ? b32.c : {32'h0, b16.c};
  endfunction

  // Offer one operand pair while idle; return the product and the number of
  // edges from acceptance until out_valid is first seen.
  task automatic do_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                       input bit s, output logic [63:0] c, output int lat);
    @(negedge clk);
    drive(sel, 1'b1, a, b, s);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, a, b, s);
    lat = 0;
    while (!ovld(sel) && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    c = getc(sel);
  endtask

  // With out_ready high: out_valid is a one-cycle pulse, in_ready returns next.
  task automatic finish_op(input int sel, input string nm);
    @(posedge clk);
    @(negedge clk);
    check({nm, " out_valid_drop"}, 64'(ovld(sel)), 64'd0);
    check({nm, " in_ready_back"},  64'(irdy(sel)), 64'd1);
  endtask

  // in_ready and out_valid must never coincide.
  always @(negedge clk) begin
    if (rst === 1'b0) check("excl24", 64'(b24.in_ready & b24.out_valid), 64'd0);
  end

  typedef struct {
    string       name;
    logic [23:0] a;
    logic [23:0] b;
    bit          s;
    logic [47:0] exp;
  } vec_t;

  vec_t vt[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] c;
    int          lat;

    vt[0] = '{"umax",        24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001};
    vt[1] = '{"s_m1x2",      24'hFFFFFF, 24'h000002, 1'b1, 48'hFFFFFFFFFFFE};
    vt[2] = '{"s_minxmin",   24'h800000, 24'h800000, 1'b1, 48'h400000000000};
    vt[3] = '{"s_minx1",     24'h800000, 24'h000001, 1'b1, 48'hFFFFFF800000};
    vt[4] = '{"u_3x5",       24'h000003, 24'h000005, 1'b0, 48'h00000000000F};
    vt[5] = '{"s_m1xm1",     24'hFFFFFF, 24'hFFFFFF, 1'b1, 48'h000000000001};
    vt[6] = '{"u_minx2",     24'h800000, 24'h000002, 1'b0, 48'h000001000000};
    vt[7] = '{"s_maxxmin",   24'h7FFFFF, 24'h800000, 1'b1, 48'hC00000800000};
    vt[8] = '{"s_0xmin",     24'h000000, 24'h800000, 1'b1, 48'h000000000000};

    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, 64'd0, 64'd0, 1'b0);
      set_ordy(s, 1'b1);
    end
    @(negedge clk);
    @(negedge clk);
    check("rst in_ready",  64'(b24.in_ready),  64'd1);
    check("rst out_valid", 64'(b24.out_valid), 64'd0);
    check("rst c",         64'(b24.c),         64'd0);
    check("rst busy",      64'(b24.busy),      64'd0);
    rst = 1'b0;

    // Directed vectors on the default configuration.
    for (int i = 0; i < 9; i++) begin
      do_op(0, 64'(vt[i].a), 64'(vt[i].b), vt[i].s, c, lat);
      check({vt[i].name, " c"},   c, 64'(vt[i].exp));
      check({vt[i].name, " lat"}, 64'(lat), 64'd3);
      finish_op(0, vt[i].name);
    end

    // Back-pressure: result held, in_ready low, a stray request ignored.
    set_ordy(0, 1'b0);
    do_op(0, 64'd3, 64'd5, 1'b0, c, lat);
    check("bp c", c, 64'hF);
    check("bp lat", 64'(lat), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) drive(0, 1'b1, 64'd7, 64'd7, 1'b0);
      if (i == 3) drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
      check("bp hold c",         64'(b24.c),         64'hF);
      check("bp hold out_valid", 64'(b24.out_valid), 64'd1);
      check("bp hold in_ready",  64'(b24.in_ready),  64'd0);
      check("bp hold busy",      64'(b24.busy),      64'd1);
    end
    set_ordy(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("bp release out_valid", 64'(b24.out_valid), 64'd0);
    check("bp release in_ready",  64'(b24.in_ready),  64'd1);
    check("bp release c",         64'(b24.c),         64'hF);
    repeat (6) @(negedge clk);
    check("bp no ghost op busy",  64'(b24.busy),      64'd0);

    // Reset asserted during the second RUN cycle.
    @(negedge clk);
    drive(0, 1'b1, 64'd9, 64'd9, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("mid busy before rst", 64'(b24.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid rst in_ready",  64'(b24.in_ready),  64'd1);
    check("mid rst out_valid", 64'(b24.out_valid), 64'd0);
    check("mid rst c",         64'(b24.c),         64'd0);
    check("mid rst busy",      64'(b24.busy),      64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("mid rst no result", 64'(b24.out_valid), 64'd0);
    do_op(0, 64'd2, 64'd2, 1'b0, c, lat);
    check("post rst c",   c, 64'd4);
    check("post rst lat", 64'(lat), 64'd3);
    finish_op(0, "post rst");

    // Streaming with in_valid held high: every result against the model,
    // spacing between acceptances fixed at N+2.
    begin
      logic [63:0] q[$];
      logic [23:0] ra, rb;
      bit          rs;
      bit          need_new = 1'b1;
      int          acc_cnt = 0, out_cnt = 0, cyc = 0, last_acc = -1;
      ra = '0; rb = '0; rs = 1'b0;
      while (out_cnt < 1000 && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        if (need_new) begin
          need_new = 1'b0;
          if (acc_cnt < 1000) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            rs = 1'($urandom_range(0, 1));
            drive(0, 1'b1, 64'(ra), 64'(rb), rs);
          end else begin
            drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
          end
        end
        if (b24.out_valid) begin
          if (q.size() > 0) check("b2b c", 64'(b24.c), q.pop_front());
          else check("b2b unexpected out_valid", 64'(b24.out_valid), 64'd0);
          out_cnt++;
        end
        if (b24.in_ready && b24.in_valid) begin
          q.push_back(ref_mul(24, 64'(ra), 64'(rb), rs));
          if (last_acc >= 0) check("b2b ii", 64'(cyc - last_acc), 64'd5);
          last_acc = cyc;
          acc_cnt++;
          need_new = 1'b1;
        end
      end
      if (out_cnt < 1000) check("b2b results", 64'(out_cnt), 64'd1000);
      @(negedge clk);
      drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
    end

    // Parameter sweep: extremes then random pairs on the other two shapes.
    for (int sel = 1; sel < 3; sel++) begin
      int          w;
      logic [63:0] m, mn, mx, ea[5], eb[5];
      bit          es[5];
      w  = wid(sel);
      m  = (64'd1 << w) - 64'd1;
      mn = 64'd1 << (w - 1);
      mx = mn - 64'd1;
      ea[0] = mn; eb[0] = mn; es[0] = 1'b1;
      ea[1] = mn; eb[1] = mx; es[1] = 1'b1;
      ea[2] = mx; eb[2] = mn; es[2] = 1'b1;
      ea[3] = mx; eb[3] = mx; es[3] = 1'b1;
      ea[4] = m;  eb[4] = m;  es[4] = 1'b0;
      for (int i = 0; i < 5; i++) begin
        do_op(sel, ea[i], eb[i], es[i], c, lat);
        check($sformatf("w%0d ext%0d c", w, i), c, ref_mul(w, ea[i], eb[i], es[i]));
        check($sformatf("w%0d ext%0d lat", w, i), 64'(lat), 64'(lat_of(sel)));
        finish_op(sel, $sformatf("w%0d ext%0d", w, i));
      end
      for (int i = 0; i < 300; i++) begin
        logic [63:0] ra, rb;
        bit          rs;
        ra = {32'($urandom), 32'($urandom)} & m;
        rb = {32'($urandom), 32'($urandom)} & m;
        rs = 1'($urandom_range(0, 1));
        do_op(sel, ra, rb, rs, c, lat);
        check($sformatf("w%0d rnd c", w), c, ref_mul(w, ra, rb, rs));
        check($sformatf("w%0d rnd lat", w), 64'(lat), 64'(lat_of(sel)));
        finish_op(sel, $sformatf("w%0d rnd", w));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
